vm_button_conditioner: RTL
==========================

# vm_button_conditioner

Front-end stage of the voting machine: takes the four raw candidate push-buttons and the mode switch, then synchronises, debounces and arbitrates them. It emits exactly one single-cycle, conflict-free vote or query event per physical press. Its outputs drive the `votingmachine` counter/display block directly, which therefore only ever sees clean one-hot, one-cycle events.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 10: consecutive stable cycles required before a debounced level changes (≥2).
- `LOCKOUT_CYCLES`, default 50: post-release dead time; used only with `VM_VOTE_LOCKOUT_EN` (≥1).

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `mode` in 1: raw switch; 0 = voting, 1 = result/query.
- `button0`..`button3` in 1 each: raw candidate buttons, active-high, asynchronous to `clock`.
- `vote_valid` out 1: one-cycle pulse; accepted vote (mode 0).
- `query_valid` out 1: one-cycle pulse; result request (mode 1).
- `cand_id` out 2: candidate index for the current pulse; holds its last value otherwise.
- `conflict` out 1: one-cycle pulse; a multi-button press was rejected.
- `mode_sync` out 1: synchronised mode level for the downstream block.

## Operation
- Each button and `mode` pass through a 2-FF synchroniser. `mode_sync` is the second flop; it is not debounced.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the debounced level.
  - When the count reaches `DEBOUNCE_CYCLES`-1 and the level still differs, the debounced level flips on the next edge and the counter clears.
  - Any cycle in which the two levels agree clears the counter. Glitches shorter than `DEBOUNCE_CYCLES` never propagate.
- FSM states IDLE, HELD, LOCKOUT:
  - IDLE, exactly one debounced button high: pulse `vote_valid` (if `mode_sync`=0) or `query_valid` (if `mode_sync`=1), load `cand_id`, go to HELD.
  - IDLE, two or more debounced buttons high in the same cycle: pulse `conflict`, no vote or query, `cand_id` unchanged, go to HELD.
  - HELD: no events are generated. Pressing additional buttons has no effect. When all debounced buttons are low, go to LOCKOUT (macro defined) or IDLE (macro undefined).
  - LOCKOUT: count `LOCKOUT_CYCLES`, then go to IDLE. Presses during LOCKOUT are ignored.
  - LOCKOUT, any button still high at expiry: go to HELD with no event. There is never an auto-vote.
- `mode_sync` is sampled only in the cycle an event is emitted. Toggling `mode` while in HELD does not create a new event.
- At most one of `vote_valid`, `query_valid`, `conflict` is high in any cycle.

## Timing
- Reset values: `vote_valid`=0, `query_valid`=0, `conflict`=0, `cand_id`=0, `mode_sync`=0; synchronisers and debounced levels 0; counters 0; FSM in IDLE.
- Latency: an event pulse goes high `DEBOUNCE_CYCLES`+3 rising edges after the first edge that samples the raw button high. Breakdown: 2 synchroniser stages + `DEBOUNCE_CYCLES` + 1 registered FSM output.
- All outputs are registered. Pulses last exactly one cycle.
- Minimum spacing between two votes: release debounce + `LOCKOUT_CYCLES` (if enabled) + press debounce.
- Reset asserted mid-press: everything clears immediately. After release of reset, a button still held is seen as a fresh press once debounced.

## Configuration
- `VM_VOTE_LOCKOUT_EN` defined: the LOCKOUT state and its counter exist, and HELD goes to LOCKOUT on full release.
- `VM_VOTE_LOCKOUT_EN` undefined: no LOCKOUT state or counter; HELD goes straight to IDLE; `LOCKOUT_CYCLES` is unused.

## Structure
- Shared package `vm_pkg`:
  - `VM_NUM_CAND`=4
  - `cand_id_t` (2-bit)
  - FSM state enum `vm_cond_state_t`
  - default debounce/lockout constants, shared with `votingmachine`.
- Sub-module `vm_debounce`: 2-FF synchroniser plus debounce counter for one bit, parameterised by `DEBOUNCE_CYCLES`. It is instantiated once per button (4×). The `mode` synchroniser is inline.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `LOCKOUT_CYCLES`=8.
- Reset, then hold `button1` high for 20 cycles with `mode`=0 → one `vote_valid` pulse with `cand_id`=1, 7 edges after the press; no further pulses while held.
- 3-cycle glitch on `button2` → no pulse of any kind; debounced level stays 0.
- `button0` and `button3` rise in the same cycle → one `conflict` pulse; `vote_valid`=0; `cand_id` unchanged.
- `mode`=1, press `button2` → one `query_valid` pulse with `cand_id`=2; `vote_valid` stays 0.
- Lockout enabled: release `button1`, re-press it 3 cycles after its debounced release → no event. Re-press after lockout expiry → a vote is emitted.
- Assert `reset` while in HELD with `button1` high, then deassert → all outputs 0 during reset. A new `vote_valid` with `cand_id`=1 follows 7 edges after the reset release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared voting-machine types, FSM encoding and default timing constants.
// The LOCKOUT state is only present when VM_VOTE_LOCKOUT_EN is defined.
package vm_pkg;

  localparam int VM_NUM_CAND            = 4;
  localparam int VM_DEBOUNCE_CYCLES_DEF = 10;
  localparam int VM_LOCKOUT_CYCLES_DEF  = 50;

  typedef logic [1:0] cand_id_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1
`ifdef VM_VOTE_LOCKOUT_EN
    ,
    ST_LOCKOUT = 2'd2
`endif
  } vm_cond_state_t;

  function automatic logic is_onehot(input logic [VM_NUM_CAND-1:0] oh);
    return (oh != '0) && ((oh & (oh - {{(VM_NUM_CAND-1){1'b0}}, 1'b1})) == '0);
  endfunction

  function automatic cand_id_t onehot_to_id(input logic [VM_NUM_CAND-1:0] oh);
    cand_id_t id;
    case (oh)
      4'b0001: id = 2'd0;
      4'b0010: id = 2'd1;
      4'b0100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/vm_debounce.sv
// One-bit 2-FF synchroniser followed by a debounce counter; the level only
// moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
module vm_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = VM_DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next debounced level and run-length of disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, debounced level and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/vm_button_conditioner.sv
// Voting-machine button front end: sync, debounce and one-event-per-press
// arbitration. Define VM_VOTE_LOCKOUT_EN to add post-release dead time.
module vm_button_conditioner
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = VM_DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = VM_LOCKOUT_CYCLES_DEF
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     mode,
  input  logic     button0,
  input  logic     button1,
  input  logic     button2,
  input  logic     button3,
  output logic     vote_valid,
  output logic     query_valid,
  output cand_id_t cand_id,
  output logic     conflict,
  output logic     mode_sync
);

  logic [VM_NUM_CAND-1:0] raw_s, db_s;
  logic                   mode_meta_q, mode_sync_q;
  vm_cond_state_t         state_q, state_d;
  logic                   vote_q, vote_d, query_q, query_d, conflict_q, conflict_d;
  cand_id_t               cand_q, cand_d;

  assign raw_s = {button3, button2, button1, button0};

  for (genvar g = 0; g < VM_NUM_CAND; g++) begin : g_db
    vm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (raw_s[g]),
      .level (db_s[g])
    );
  end

`ifdef VM_VOTE_LOCKOUT_EN
  localparam int             LCW       = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCKOUT_CYCLES - 1);
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lockout;
  assign unused_lockout = (LOCKOUT_CYCLES > 0);
`endif

  // Mode switch synchroniser; deliberately not debounced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
    end else begin
      mode_meta_q <= mode;
      mode_sync_q <= mode_meta_q;
    end
  end

  // Arbitration: one event per press, then wait for a full release.
  always_comb begin
    state_d    = state_q;
    vote_d     = 1'b0;
    query_d    = 1'b0;
    conflict_d = 1'b0;
    cand_d     = cand_q;
`ifdef VM_VOTE_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(db_s)) begin
          vote_d  = ~mode_sync_q;
          query_d = mode_sync_q;
          cand_d  = onehot_to_id(db_s);
          state_d = ST_HELD;
        end else if (db_s != '0) begin
          conflict_d = 1'b1;
          state_d    = ST_HELD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (db_s == '0) begin
`ifdef VM_VOTE_LOCKOUT_EN
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_HELD;
        end
      end
`ifdef VM_VOTE_LOCKOUT_EN
      // A button still down at expiry re-arms via HELD, never an auto-vote.
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d = '0;
          state_d    = (db_s != '0) ? ST_HELD : ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered event outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vote_q     <= 1'b0;
      query_q    <= 1'b0;
      conflict_q <= 1'b0;
      cand_q     <= 2'd0;
`ifdef VM_VOTE_LOCKOUT_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vote_q     <= vote_d;
      query_q    <= query_d;
      conflict_q <= conflict_d;
      cand_q     <= cand_d;
`ifdef VM_VOTE_LOCKOUT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign vote_valid  = vote_q;
  assign query_valid = query_q;
  assign conflict    = conflict_q;
  assign cand_id     = cand_q;
  assign mode_sync   = mode_sync_q;

endmodule
